// File: rtl/alu_pipe_nbit.sv
// Two-stage valid/ready pipelined ALU: S1 registers operands, S2 registers result and flags.
// Eight opcodes (add/sub/logic/shift) with carry, signed overflow, zero and negative flags.
module alu_pipe_nbit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf_out,
    output logic             zero_out,
    output logic             neg_out
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpNot = 3'd5;
    localparam logic [2:0] OpShl = 3'd6;
    localparam logic [2:0] OpShr = 3'd7;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_c;
    logic [2:0]       s1_op;
    logic             s2_valid;
    logic             s1_en;
    logic             s2_en;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [SHW-1:0]   sh_n;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    always_comb begin
        sh_n  = s1_b[SHW-1:0];
        sum   = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_c};
        // Bit WIDTH of the extended difference is the borrow.
        diff  = {1'b0, s1_a} - {1'b0, s1_b} - {{WIDTH{1'b0}}, s1_c};
        // One guard bit catches the last bit shifted out; n = 0 leaves it zero.
        shl_w = {1'b0, s1_a} << sh_n;
        shr_w = {s1_a, 1'b0} >> sh_n;

        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (s1_op)
            OpAdd: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OpSub: begin
                res_d   = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
                ovf_d   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            end
            OpAnd: res_d = s1_a & s1_b;
            OpOr:  res_d = s1_a | s1_b;
            OpXor: res_d = s1_a ^ s1_b;
            OpNot: res_d = ~s1_a;
            OpShl: begin
                res_d   = shl_w[WIDTH-1:0];
                carry_d = shl_w[WIDTH];
            end
            OpShr: begin
                res_d   = shr_w[WIDTH:1];
                carry_d = shr_w[0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= 1'b0;
            s1_op     <= '0;
            s2_valid  <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            ovf_out   <= 1'b0;
            zero_out  <= 1'b0;
            neg_out   <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a  <= a_in;
                    s1_b  <= b_in;
                    s1_c  <= c_in;
                    s1_op <= opcode;
                end
            end
            // Bubbles advance the valid bit only; result data holds its last value.
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result    <= res_d;
                    carry_out <= carry_d;
                    ovf_out   <= ovf_d;
                    zero_out  <= (res_d == '0);
                    neg_out   <= res_d[MSB];
                end
            end
        end
    end

endmodule
